// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO owner with iterative shift-add multiply and restoring divide
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_mul;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               op_arith;
    logic               op_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    always_comb begin
        op_arith  = (op[2] == 1'b0);
        op_signed = (op[0] == 1'b0);
        sign_a    = op_signed & rs_val[WIDTH-1];
        sign_b    = op_signed & rt_val[WIDTH-1];
        mag_a     = sign_a ? -rs_val : rs_val;
        mag_b     = sign_b ? -rt_val : rt_val;
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   step_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb};
        if (is_mul) begin
            step_next = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_trial[WIDTH]) begin
            step_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            step_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;

    // A zero divisor leaves |dividend| as remainder, so only the quotient needs forcing.
    always_comb begin
        fix_prod = neg_q ? -acc : acc;
        fix_q    = div_zero ? {WIDTH{1'b1}}
                 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        fix_r    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    assign busy  = (state == RUN) || (state == FIX);
    assign stall = hilo_rd & (busy | (start & op_arith));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            opb      <= '0;
            is_mul   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        if (op_arith) begin
                            state    <= RUN;
                            count    <= '0;
                            is_mul   <= ~op[1];
                            opb      <= op[1] ? mag_b : mag_a;
                            acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                            neg_q    <= sign_a ^ sign_b;
                            neg_r    <= sign_a;
                            div_zero <= (rt_val == '0);
                        end else if (op == 3'b100) begin
                            hi <= rs_val;
                        end else if (op == 3'b101) begin
                            lo <= rs_val;
                        end
                    end
                end
                RUN: begin
                    acc   <= step_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_mul) begin
                        {hi, lo} <= fix_prod;
                    end else begin
                        hi <= fix_r;
                        lo <= fix_q;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - randomized bench for hilo_muldiv_ctrl against an arithmetic model
module tb_hilo_muldiv_ctrl;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  rs_val;
    logic [W-1:0]  rt_val;
    logic          hilo_rd;
    logic          busy;
    logic          done;
    logic          stall;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_hi = '0;
    logic [W-1:0]  exp_lo = '0;

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .hilo_rd(hilo_rd), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int          sa;
        int          sb;
        sa = a;
        sb = b;
        case (o)
            3'd0: r = longint'(sa) * longint'(sb);
            3'd1: r = {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else if (o == 3'd2) begin
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
                    else r = {32'(sa % sb), 32'(sa / sb)};
                end else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Entered and left at negedge+1; leaves the DUT in its DONE cycle.
    task automatic muldiv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
        logic [63:0] r;
        int          cyc;
        logic        rd;
        r  = model(o, a, b);
        rd = 1'($urandom_range(0, 1));
        start = 1'b1; op = o; rs_val = a; rt_val = b; hilo_rd = rd;
        #1 check("issue_stall", stall, rd);
        @(negedge clk);
        start = 1'b0; rs_val = $urandom; rt_val = $urandom;
        cyc = 1;
        while (!done && cyc <= 40) begin
            check("busy", busy, 1);
            check("hi_stable", hi, exp_hi);
            check("lo_stable", lo, exp_lo);
            if (inject && cyc == 5) begin
                start = 1'b1; op = 3'd1; rs_val = 32'd2; rt_val = 32'd3;
            end else begin
                start = 1'b0;
            end
            hilo_rd = 1'($urandom_range(0, 1));
            #1 check("run_stall", stall, hilo_rd);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", cyc, 34);
        check("done", done, 1);
        check("busy_at_done", busy, 0);
        check("hi_result", hi, r[63:32]);
        check("lo_result", lo, r[31:0]);
        hilo_rd = 1'b1;
        #1 check("done_stall", stall, 0);
        hilo_rd = 1'b0;
        exp_hi = r[63:32];
        exp_lo = r[31:0];
    endtask

    task automatic simple(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1; op = o; rs_val = a; hilo_rd = 1'($urandom_range(0, 1));
        #1 check("mt_stall", stall, 0);
        check("mt_old_hi", hi, exp_hi);
        check("mt_old_lo", lo, exp_lo);
        @(negedge clk);
        start = 1'b0;
        if (o == 3'd4) exp_hi = a;
        if (o == 3'd5) exp_lo = a;
        check("mt_done", done, 0);
        check("mt_busy", busy, 0);
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
        hilo_rd = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0; hilo_rd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst = 1'b0;
        #1;

        muldiv(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        muldiv(3'd0, 32'hFFFFFFFD, 32'd5, 1'b0);
        muldiv(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        muldiv(3'd3, 32'd7, 32'd0, 1'b0);
        muldiv(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        muldiv(3'd2, 32'hFFFFFFFB, 32'd0, 1'b0);
        muldiv(3'd3, 32'd100, 32'd7, 1'b1);
        @(negedge clk);
        check("done_pulse_end", done, 0);
        #1;
        simple(3'd4, 32'h1234);
        simple(3'd5, 32'h5678);

        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 9);
            if (k <= 5) muldiv(3'($urandom_range(0, 3)), pick(), pick(), 1'b0);
            else if (k == 6) simple(3'd4, $urandom);
            else if (k == 7) simple(3'd5, $urandom);
            else if (k == 8) simple(3'($urandom_range(6, 7)), $urandom);
            else muldiv(3'($urandom_range(0, 3)), pick(), pick(), 1'b1);
        end

        simple(3'd4, 32'hDEAD);
        start = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("midrst_no_done", done, 0);
        end
        #1;
        muldiv(3'd1, 32'h0001_0000, 32'h0003_0000, 1'b0);
        @(negedge clk);
        check("final_done_low", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
